// File: rtl/vip_stream_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : vip_stream_encoder_if
// Description : Bundle of the pixel input, the control-packet request and
//               the Avalon-ST video output of the VIP stream encoder.
//               master : the environment side (drives pixels, requests and
//                        the output ready)
//               slave  : the encoder side
// Ports       : din_ready/din_valid/din_data/end_of_video   pixel input
//               vip_ctrl_send/width/height/interlaced/
//               vip_ctrl_busy                               control request
//               dout_ready/dout_valid/dout_data/
//               dout_startofpacket/dout_endofpacket         video output
// Revision    : 1.0 - initial release
// ============================================================================
interface vip_stream_encoder_if #(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3
);
    localparam int c_DATA_W = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

    logic                din_ready;
    logic                din_valid;
    logic [c_DATA_W-1:0] din_data;
    logic                end_of_video;
    logic                vip_ctrl_send;
    logic [15:0]         width;
    logic [15:0]         height;
    logic [3:0]          interlaced;
    logic                vip_ctrl_busy;
    logic                dout_ready;
    logic                dout_valid;
    logic [c_DATA_W-1:0] dout_data;
    logic                dout_startofpacket;
    logic                dout_endofpacket;

    modport master (
        input  din_ready, vip_ctrl_busy, dout_valid, dout_data,
               dout_startofpacket, dout_endofpacket,
        output din_valid, din_data, end_of_video, vip_ctrl_send,
               width, height, interlaced, dout_ready
    );

    modport slave (
        output din_ready, vip_ctrl_busy, dout_valid, dout_data,
               dout_startofpacket, dout_endofpacket,
        input  din_valid, din_data, end_of_video, vip_ctrl_send,
               width, height, interlaced, dout_ready
    );
endinterface
`default_nettype wire

// File: rtl/vip_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : vip_stream_encoder
// Description : Wraps a raw pixel stream into Avalon-ST video packets. On
//               request it emits a control packet (width, height,
//               interlaced as nibbles); on pixel arrival it emits a video
//               header followed by the pixels up to end_of_video. All output
//               signals come from a single one-beat output register.
// Ports       : clk, rst (sync, active high)
//               bus : vip_stream_encoder_if.slave (pixel in, control
//                     request, video out)
// Revision    : 1.0 - initial release
// ============================================================================
module vip_stream_encoder #(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    vip_stream_encoder_if.slave   bus
);
    localparam int c_DATA_W     = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int c_NIBBLES    = 9;
    localparam int c_CTRL_BEATS = (c_NIBBLES + SYMBOLS_PER_BEAT - 1) / SYMBOLS_PER_BEAT;
    localparam logic [3:0] c_LAST_BEAT = 4'(c_CTRL_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CTRL_HDR  = 3'd1,
        CTRL_DATA = 3'd2,
        VID_HDR   = 3'd3,
        VID_DATA  = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [15:0]         r_width, r_height;
    logic [3:0]          r_interlaced;
    logic [3:0]          r_cnt;
    logic                r_dout_valid, r_dout_sop, r_dout_eop;
    logic [c_DATA_W-1:0] r_dout_data;

    logic                w_load, w_capture, w_cnt_clr, w_cnt_inc, w_din_ready;
    logic                w_beat_vld, w_beat_sop, w_beat_eop;
    logic [c_DATA_W-1:0] w_beat_data, w_ctrl_data;

    // Control nibbles in transmit order: nibble k sits at bits [4k+3:4k].
    logic [4*c_NIBBLES-1:0] w_nibs;
    assign w_nibs = {r_interlaced,
                     r_height[3:0], r_height[7:4], r_height[11:8], r_height[15:12],
                     r_width[3:0],  r_width[7:4],  r_width[11:8],  r_width[15:12]};

    // Pre-arrange every control data beat; symbols past the ninth nibble stay 0.
    logic [c_CTRL_BEATS-1:0][c_DATA_W-1:0] w_ctrl_beats;
    for (genvar b = 0; b < c_CTRL_BEATS; b++) begin : g_beat
        for (genvar s = 0; s < SYMBOLS_PER_BEAT; s++) begin : g_sym
            if (b * SYMBOLS_PER_BEAT + s < c_NIBBLES) begin : g_nib
                assign w_ctrl_beats[b][s*BITS_PER_SYMBOL +: BITS_PER_SYMBOL] =
                    BITS_PER_SYMBOL'(w_nibs[(b*SYMBOLS_PER_BEAT + s)*4 +: 4]);
            end else begin : g_pad
                assign w_ctrl_beats[b][s*BITS_PER_SYMBOL +: BITS_PER_SYMBOL] = '0;
            end
        end
    end

    always_comb begin
        w_ctrl_data = '0;
        for (int b = 0; b < c_CTRL_BEATS; b++) begin
            if (r_cnt == 4'(b)) w_ctrl_data = w_ctrl_beats[b];
        end
    end

    // The output register may take a new beat when empty or being drained.
    assign w_load = !r_dout_valid || bus.dout_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_din_ready = 1'b0;
        w_beat_vld  = 1'b0;
        w_beat_sop  = 1'b0;
        w_beat_eop  = 1'b0;
        w_beat_data = '0;
        unique case (r_state)
            IDLE: begin
                // A control request has priority over a waiting pixel.
                if (bus.vip_ctrl_send) begin
                    w_capture   = 1'b1;
                    w_state_nxt = CTRL_HDR;
                end else if (bus.din_valid) begin
                    w_state_nxt = VID_HDR;
                end
            end
            CTRL_HDR: if (w_load) begin
                w_beat_vld  = 1'b1;
                w_beat_sop  = 1'b1;
                w_beat_data = c_DATA_W'(4'hF);
                w_cnt_clr   = 1'b1;
                w_state_nxt = CTRL_DATA;
            end
            CTRL_DATA: if (w_load) begin
                w_beat_vld  = 1'b1;
                w_beat_data = w_ctrl_data;
                w_cnt_inc   = 1'b1;
                if (r_cnt == c_LAST_BEAT) begin
                    w_beat_eop  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            VID_HDR: if (w_load) begin
                w_beat_vld  = 1'b1;
                w_beat_sop  = 1'b1;
                w_state_nxt = VID_DATA;
            end
            VID_DATA: begin
                w_din_ready = w_load;
                if (bus.din_valid && w_load) begin
                    w_beat_vld  = 1'b1;
                    w_beat_data = bus.din_data;
                    w_beat_eop  = bus.end_of_video;
                    if (bus.end_of_video) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_width      <= '0;
            r_height     <= '0;
            r_interlaced <= '0;
        end else if (w_capture) begin
            r_width      <= bus.width;
            r_height     <= bus.height;
            r_interlaced <= bus.interlaced;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)            r_cnt <= '0;
        else if (w_cnt_clr) r_cnt <= '0;
        else if (w_cnt_inc) r_cnt <= r_cnt + 4'd1;
    end

    // Output register: holds its beat while stalled, empties when no beat follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout_valid <= 1'b0;
            r_dout_sop   <= 1'b0;
            r_dout_eop   <= 1'b0;
            r_dout_data  <= '0;
        end else if (w_load) begin
            r_dout_valid <= w_beat_vld;
            if (w_beat_vld) begin
                r_dout_sop  <= w_beat_sop;
                r_dout_eop  <= w_beat_eop;
                r_dout_data <= w_beat_data;
            end
        end
    end

    assign bus.din_ready          = w_din_ready;
    assign bus.vip_ctrl_busy      = (r_state != IDLE);
    assign bus.dout_valid         = r_dout_valid;
    assign bus.dout_startofpacket = r_dout_sop;
    assign bus.dout_endofpacket   = r_dout_eop;
    assign bus.dout_data          = r_dout_data;
endmodule
`default_nettype wire

// File: tb/tb_vip_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vip_stream_encoder
// Description : Directed self-checking bench for vip_stream_encoder:
//               control packet, video packet, backpressure, simultaneous
//               start, request during a frame and reset mid-frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vip_stream_encoder;
    localparam int c_BPS = 8;
    localparam int c_SPB = 3;
    localparam int c_DW  = c_BPS * c_SPB;

    typedef struct packed {
        logic            sop;
        logic            eop;
        logic [c_DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vip_stream_encoder_if #(.BITS_PER_SYMBOL(c_BPS), .SYMBOLS_PER_BEAT(c_SPB)) bus ();

    vip_stream_encoder #(.BITS_PER_SYMBOL(c_BPS), .SYMBOLS_PER_BEAT(c_SPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    bit    ready_toggle = 1'b0;
    bit    mon_en       = 1'b0;
    beat_t obs_q[$];
    beat_t exp_q[$];
    int    obs_cyc[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Output ready: held high, or alternating 1010... per cycle.
    initial begin
        bus.dout_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.dout_ready = ready_toggle ? ~bus.dout_ready : 1'b1;
        end
    end

    // Output monitor: records transfers, checks stall stability and din_ready.
    initial begin
        beat_t prev;
        bit    prev_stall;
        beat_t cur;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            cyc++;
            #3;
            if (rst || !mon_en) begin
                prev_stall = 1'b0;
            end else begin
                cur = '{sop: bus.dout_startofpacket, eop: bus.dout_endofpacket, data: bus.dout_data};
                if (prev_stall) chk("stall_hold", 64'(cur), 64'(prev));
                if (bus.dout_valid && bus.dout_ready) begin
                    obs_q.push_back(cur);
                    obs_cyc.push_back(cyc);
                end
                if (bus.dout_valid && !bus.dout_ready)
                    chk("stall_din_ready", 64'(bus.din_ready), 64'd0);
                prev_stall = bus.dout_valid && !bus.dout_ready;
                prev       = cur;
            end
        end
    end

    // Called on a negedge; request lasts one cycle.
    task automatic send_ctrl();
        bus.width         = 16'd1920;
        bus.height        = 16'd1080;
        bus.interlaced    = 4'd0;
        bus.vip_ctrl_send = 1'b1;
        @(negedge clk);
        bus.vip_ctrl_send = 1'b0;
    endtask

    // Called on a negedge; pixel k has value k*0x111111.
    task automatic send_pixels(input int n, input int first, input bit eov_last);
        for (int i = 0; i < n; i++) begin
            int waited;
            bit acc;
            waited = 0;
            acc    = 1'b0;
            bus.din_valid    = 1'b1;
            bus.din_data     = c_DW'(32'h111111 * (first + i));
            bus.end_of_video = eov_last && (i == n - 1);
            while (!acc && waited < 100) begin
                #1;
                acc = bus.din_ready;
                @(negedge clk);
                waited++;
            end
            if (!acc) chk("din_accept_timeout", 64'd0, 64'd1);
        end
        bus.din_valid    = 1'b0;
        bus.end_of_video = 1'b0;
    endtask

    // Hand-computed control packet for 1920x1080 progressive.
    task automatic exp_ctrl();
        exp_q.push_back('{sop: 1'b1, eop: 1'b0, data: 24'h00000F});
        exp_q.push_back('{sop: 1'b0, eop: 1'b0, data: 24'h080700});
        exp_q.push_back('{sop: 1'b0, eop: 1'b0, data: 24'h040000});
        exp_q.push_back('{sop: 1'b0, eop: 1'b1, data: 24'h000803});
    endtask

    task automatic exp_vid(input int n, input int first);
        exp_q.push_back('{sop: 1'b1, eop: 1'b0, data: 24'h000000});
        for (int i = 0; i < n; i++)
            exp_q.push_back('{sop: 1'b0, eop: (i == n - 1), data: c_DW'(32'h111111 * (first + i))});
    endtask

    task automatic drain_compare(input string tag);
        int t;
        t = 0;
        while (obs_q.size() < exp_q.size() && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    endtask

    task automatic clear_q();
        obs_q.delete();
        exp_q.delete();
        obs_cyc.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        rst               = 1'b1;
        bus.din_valid     = 1'b0;
        bus.din_data      = '0;
        bus.end_of_video  = 1'b0;
        bus.vip_ctrl_send = 1'b0;
        bus.width         = '0;
        bus.height        = '0;
        bus.interlaced    = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 64'(bus.dout_valid), 64'd0);
        chk("rst_sop",   64'(bus.dout_startofpacket), 64'd0);
        chk("rst_eop",   64'(bus.dout_endofpacket), 64'd0);
        chk("rst_data",  64'(bus.dout_data), 64'd0);
        chk("rst_busy",  64'(bus.vip_ctrl_busy), 64'd0);
        chk("rst_din_ready", 64'(bus.din_ready), 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Control packet, ready high.
        send_ctrl();
        busy_cnt = 0;
        repeat (8) begin
            #1;
            if (bus.vip_ctrl_busy) busy_cnt++;
            @(negedge clk);
        end
        chk("ctrl_busy_cycles", 64'(busy_cnt), 64'd4);
        exp_ctrl();
        drain_compare("ctrl");
        chk("ctrl_consecutive", (obs_cyc.size() >= 4) ? 64'(obs_cyc[3] - obs_cyc[0]) : 64'hFFFF, 64'd3);
        clear_q();

        // Video packet, ready high.
        exp_vid(4, 1);
        send_pixels(4, 1, 1'b1);
        drain_compare("vid");
        chk("vid_idle_busy", 64'(bus.vip_ctrl_busy), 64'd0);
        clear_q();

        // Both packets under alternating ready.
        ready_toggle = 1'b1;
        send_ctrl();
        exp_ctrl();
        drain_compare("bp_ctrl");
        clear_q();
        exp_vid(4, 1);
        send_pixels(4, 1, 1'b1);
        drain_compare("bp_vid");
        clear_q();
        ready_toggle = 1'b0;
        repeat (2) @(negedge clk);

        // Request and pixel arrive in the same IDLE cycle.
        fork
            send_ctrl();
            send_pixels(2, 5, 1'b1);
        join
        exp_ctrl();
        exp_vid(2, 5);
        drain_compare("simul");
        clear_q();

        // Request raised during a frame.
        send_pixels(1, 1, 1'b0);
        bus.width         = 16'd1920;
        bus.height        = 16'd1080;
        bus.interlaced    = 4'd0;
        bus.vip_ctrl_send = 1'b1;
        #1;
        chk("mid_busy", 64'(bus.vip_ctrl_busy), 64'd1);
        @(negedge clk);
        send_pixels(3, 2, 1'b1);
        #1;
        chk("mid_idle_gap", 64'(bus.vip_ctrl_busy), 64'd0);
        @(negedge clk);
        #1;
        chk("mid_send_taken", 64'(bus.vip_ctrl_busy), 64'd1);
        bus.vip_ctrl_send = 1'b0;
        @(negedge clk);
        exp_vid(4, 1);
        exp_ctrl();
        drain_compare("mid");
        chk("mid_hdr_gap", (obs_cyc.size() >= 6) ? 64'(obs_cyc[5] - obs_cyc[4]) : 64'hFFFF, 64'd2);
        clear_q();

        // Reset after two pixels of a frame.
        send_pixels(2, 1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_valid", 64'(bus.dout_valid), 64'd0);
        chk("midrst_busy",  64'(bus.vip_ctrl_busy), 64'd0);
        chk("midrst_din_ready", 64'(bus.din_ready), 64'd0);
        rst = 1'b0;
        #5;
        clear_q();
        @(negedge clk);
        exp_vid(1, 7);
        send_pixels(1, 7, 1'b1);
        drain_compare("after_rst");
        clear_q();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
